// File: rtl/seg7_mux_n_if.sv
// Display-side bundle for seg7_mux_n: data/control in from the host, cathode/anode drive out.
interface seg7_mux_n_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_blank;
  logic [3:0]              brightness;
  logic [0:6]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output value, dp_in, load, lz_blank, brightness,
    input  seg, dp, digit, pending, frame_done
  );
  modport slave (
    input  value, dp_in, load, lz_blank, brightness,
    output seg, dp, digit, pending, frame_done
  );
endinterface

// File: rtl/seg7_mux_n.sv
// Time-multiplexed N-digit hex 7-segment driver with frame-aligned shadow update.
// Optional anode PWM dimming when SEG7_MUX_PWM_EN is defined.
module seg7_mux_n_lane (
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output logic [0:6] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    if (!i_blank) begin
      case (i_nib)
        4'h0: o_seg = 7'b0000001;
        4'h1: o_seg = 7'b1001111;
        4'h2: o_seg = 7'b0010010;
        4'h3: o_seg = 7'b0000110;
        4'h4: o_seg = 7'b1001100;
        4'h5: o_seg = 7'b0100100;
        4'h6: o_seg = 7'b0100000;
        4'h7: o_seg = 7'b0001111;
        4'h8: o_seg = 7'b0000000;
        4'h9: o_seg = 7'b0000100;
        4'hA: o_seg = 7'b0001000;
        4'hB: o_seg = 7'b1100000;
        4'hC: o_seg = 7'b0110001;
        4'hD: o_seg = 7'b1000010;
        4'hE: o_seg = 7'b0110000;
        4'hF: o_seg = 7'b0111000;
      endcase
    end
  end
endmodule

module seg7_mux_n #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  seg7_mux_n_if.slave  bus
);
  localparam int TW = $clog2(REFRESH_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [TW-1:0]                r_timer;
  logic [IW-1:0]                r_idx;
  logic [NUM_DIGITS-1:0][3:0]   r_sh_val, r_act_val;
  logic [NUM_DIGITS-1:0]        r_sh_dp, r_act_dp;
  logic                         r_pending, r_frame_done;
  logic [0:6]                   r_seg;
  logic                         r_dp;
  logic [NUM_DIGITS-1:0]        r_digit;
  logic                         w_slot_end, w_frame_end, w_anode_en;
  logic [NUM_DIGITS-1:0]        w_blank;
  logic [NUM_DIGITS-1:0][0:6]   w_glyph;
  logic [NUM_DIGITS-1:0][3:0]   w_value;

  assign w_value     = bus.value;
  assign w_slot_end  = (r_timer == TW'(REFRESH_CYCLES - 1));
  assign w_frame_end = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
      r_idx   <= '0;
    end else if (w_slot_end) begin
      r_timer <= '0;
      r_idx   <= w_frame_end ? '0 : r_idx + 1'b1;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // A load on the boundary cycle wins pending; the transfer still takes the old shadow.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (bus.load) begin
        r_sh_val <= w_value;
        r_sh_dp  <= bus.dp_in;
      end
      if (w_frame_end && r_pending) begin
        r_act_val <= r_sh_val;
        r_act_dp  <= r_sh_dp;
      end
      if (bus.load)         r_pending <= 1'b1;
      else if (w_frame_end) r_pending <= 1'b0;
    end
  end

  // Blank every digit above the highest non-zero nibble; digit 0 always shows.
  always_comb begin
    logic nz;
    nz      = 1'b0;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz         = nz | (|r_act_val[i]);
      w_blank[i] = bus.lz_blank && !nz;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seg7_mux_n_lane u_lane (
      .i_nib   (r_act_val[g]),
      .i_blank (w_blank[g]),
      .o_seg   (w_glyph[g])
    );
  end

`ifdef SEG7_MUX_PWM_EN
  logic [3:0] r_pwm;
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) r_pwm <= '0;
    else        r_pwm <= r_pwm + 1'b1;
  end
  assign w_anode_en = (r_pwm <= bus.brightness);
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^bus.brightness;
  assign w_anode_en          = 1'b1;
`endif

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_digit      <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_glyph[r_idx];
      r_dp         <= ~r_act_dp[r_idx];
      r_digit      <= w_anode_en ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_frame_done <= w_frame_end;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.digit      = r_digit;
  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_mux_n.sv
// Directed bench for seg7_mux_n with 4 digits and 4-clock slots (frame = 16 clocks).
module tb_seg7_mux_n;
  logic clk_100MHz = 1'b0;
  logic reset      = 1'b0;
  int   tests = 0;
  int   fails = 0;

  seg7_mux_n_if #(.NUM_DIGITS(4)) bus ();
  seg7_mux_n #(.NUM_DIGITS(4), .REFRESH_CYCLES(4)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_100MHz); #1; end
  endtask

  // After this returns, the next rising edge is the first edge of slot 0.
  task automatic do_reset();
    reset = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
    bus.lz_blank = 1'b0; bus.brightness = 4'hF;
    repeat (2) @(posedge clk_100MHz);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.load = 1'b1; bus.value = 16'hFFFF; bus.dp_in = 4'hF;
    step(3);
    tests++; if (bus.seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg got %b want 1111111", bus.seg); end
    tests++; if (bus.dp !== 1'b1) begin fails++; $display("FAIL reset_dp got %b want 1", bus.dp); end
    tests++; if (bus.digit !== 4'hF) begin fails++; $display("FAIL reset_digit got %b want 1111", bus.digit); end
    tests++; if (bus.pending !== 1'b0) begin fails++; $display("FAIL reset_pending got %b want 0", bus.pending); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    bus.load = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] ed;
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      step(1);
      ed = ~(4'b0001 << (((n - 1) / 4) % 4));
      tests++; if (bus.digit !== ed) begin fails++; $display("FAIL scan_digit e%0d got %b want %b", n, bus.digit, ed); end
      tests++; if (bus.frame_done !== (n % 16 == 0)) begin fails++; $display("FAIL scan_frame_done e%0d got %b want %b", n, bus.frame_done, (n % 16 == 0)); end
      tests++; if (bus.seg !== 7'b0000001) begin fails++; $display("FAIL scan_seg e%0d got %b want 0000001", n, bus.seg); end
    end
  endtask

  task automatic test_load();
    logic [0:6] tbl [4];
    logic [3:0] ed;
    int idx;
    tbl[0] = 7'b0111000; tbl[1] = 7'b0001000; tbl[2] = 7'b0010010; tbl[3] = 7'b1001111;
    do_reset();
    step(5);
    bus.value = 16'h12AF; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    tests++; if (bus.pending !== 1'b1) begin fails++; $display("FAIL load_pending got %b want 1", bus.pending); end
    for (int n = 7; n <= 16; n++) begin
      step(1);
      tests++; if (bus.seg !== 7'b0000001) begin fails++; $display("FAIL load_old_seg e%0d got %b want 0000001", n, bus.seg); end
    end
    tests++; if (bus.pending !== 1'b0) begin fails++; $display("FAIL load_pending_clr got %b want 0", bus.pending); end
    for (int n = 17; n <= 32; n++) begin
      step(1);
      idx = (n - 17) / 4;
      ed  = ~(4'b0001 << idx);
      tests++; if (bus.seg !== tbl[idx]) begin fails++; $display("FAIL load_new_seg e%0d got %b want %b", n, bus.seg, tbl[idx]); end
      tests++; if (bus.digit !== ed) begin fails++; $display("FAIL load_new_digit e%0d got %b want %b", n, bus.digit, ed); end
    end
  endtask

  task automatic test_lz();
    logic [0:6] es;
    logic       ep;
    int idx;
    do_reset();
    bus.lz_blank = 1'b1; bus.value = 16'h0005; bus.dp_in = 4'b1010; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(15);
    for (int n = 17; n <= 32; n++) begin
      step(1);
      idx = (n - 17) / 4;
      es  = (idx == 0) ? 7'b0100100 : 7'b1111111;
      ep  = !(idx == 1 || idx == 3);
      tests++; if (bus.seg !== es) begin fails++; $display("FAIL lz_seg e%0d got %b want %b", n, bus.seg, es); end
      tests++; if (bus.dp !== ep) begin fails++; $display("FAIL lz_dp e%0d got %b want %b", n, bus.dp, ep); end
      if (n == 20) begin bus.value = 16'h0000; bus.dp_in = 4'b0000; bus.load = 1'b1; end
      else bus.load = 1'b0;
    end
    for (int n = 33; n <= 48; n++) begin
      step(1);
      idx = (n - 33) / 4;
      es  = (idx == 0 || n >= 42) ? 7'b0000001 : 7'b1111111;
      tests++; if (bus.seg !== es) begin fails++; $display("FAIL lz_zero_seg e%0d got %b want %b", n, bus.seg, es); end
      tests++; if (bus.dp !== 1'b1) begin fails++; $display("FAIL lz_zero_dp e%0d got %b want 1", n, bus.dp); end
      if (n == 41) bus.lz_blank = 1'b0;
    end
  endtask

  task automatic test_boundary();
    do_reset();
    bus.value = 16'h1111; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(14);
    bus.value = 16'h2222; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    tests++; if (bus.pending !== 1'b1) begin fails++; $display("FAIL bnd_pending got %b want 1", bus.pending); end
    tests++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL bnd_frame_done got %b want 1", bus.frame_done); end
    for (int n = 17; n <= 32; n++) begin
      step(1);
      tests++; if (bus.seg !== 7'b1001111) begin fails++; $display("FAIL bnd_old_seg e%0d got %b want 1001111", n, bus.seg); end
      tests++; if (bus.pending !== (n < 32)) begin fails++; $display("FAIL bnd_pending e%0d got %b want %b", n, bus.pending, (n < 32)); end
    end
    for (int n = 33; n <= 48; n++) begin
      step(1);
      tests++; if (bus.seg !== 7'b0010010) begin fails++; $display("FAIL bnd_new_seg e%0d got %b want 0010010", n, bus.seg); end
    end
  endtask

  task automatic test_pwm();
    int cnt, want;
    do_reset();
    bus.brightness = 4'd3;
    step(16);
    cnt = 0;
    for (int n = 0; n < 16; n++) begin step(1); if (bus.digit !== 4'hF) cnt++; end
`ifdef SEG7_MUX_PWM_EN
    want = 4;
`else
    want = 16;
`endif
    tests++; if (cnt !== want) begin fails++; $display("FAIL pwm_b3_on got %0d want %0d", cnt, want); end
    bus.brightness = 4'd15;
    step(2);
    cnt = 0;
    for (int n = 0; n < 16; n++) begin step(1); if (bus.digit !== 4'hF) cnt++; end
    tests++; if (cnt !== 16) begin fails++; $display("FAIL pwm_b15_on got %0d want 16", cnt); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ed;
    do_reset();
    bus.value = 16'h3333; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(2);
    tests++; if (bus.pending !== 1'b1) begin fails++; $display("FAIL rmid_pending_pre got %b want 1", bus.pending); end
    #2 reset = 1'b0;
    #1;
    tests++; if (bus.seg !== 7'b1111111) begin fails++; $display("FAIL rmid_seg got %b want 1111111", bus.seg); end
    tests++; if (bus.digit !== 4'hF) begin fails++; $display("FAIL rmid_digit got %b want 1111", bus.digit); end
    tests++; if (bus.dp !== 1'b1) begin fails++; $display("FAIL rmid_dp got %b want 1", bus.dp); end
    tests++; if (bus.pending !== 1'b0) begin fails++; $display("FAIL rmid_pending got %b want 0", bus.pending); end
    @(posedge clk_100MHz);
    #1 reset = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      step(1);
      ed = ~(4'b0001 << (((n - 1) / 4) % 4));
      tests++; if (bus.seg !== 7'b0000001) begin fails++; $display("FAIL rmid_post_seg e%0d got %b want 0000001", n, bus.seg); end
      tests++; if (bus.digit !== ed) begin fails++; $display("FAIL rmid_post_digit e%0d got %b want %b", n, bus.digit, ed); end
      tests++; if (bus.pending !== 1'b0) begin fails++; $display("FAIL rmid_post_pending e%0d got %b want 0", n, bus.pending); end
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
    bus.lz_blank = 1'b0; bus.brightness = 4'hF;
    test_reset();
    test_scan();
    test_load();
    test_lz();
    test_boundary();
    test_pwm();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_mux_n.md
SEG7_MUX_N -- requirements
Module: seg7_mux_n

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, meaning the number of multiplexed digits (legal range 2..16).
REQ-002 The block SHALL have parameter REFRESH_CYCLES, default 100000, meaning clocks per digit slot (1 ms at 100 MHz; minimum 2).
REQ-003 The block SHALL have port clk_100MHz, input, 1 bit, system clock; all logic rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit, reset, asynchronous, active-low.
REQ-005 The block SHALL have port value, input, 4*NUM_DIGITS bits, hex nibbles; nibble i drives digit i, where digit 0 is least significant.
REQ-006 The block SHALL have port dp_in, input, NUM_DIGITS bits, decimal point request per digit, active-high.
REQ-007 The block SHALL have port load, input, 1 bit, single-cycle strobe that captures value/dp_in into the shadow register.
REQ-008 The block SHALL have port lz_blank, input, 1 bit, leading-zero suppression enable.
REQ-009 The block SHALL have port brightness, input, 4 bits, PWM duty level.
REQ-010 The block SHALL have port seg, output, 7 bits [0:6], cathodes a..g with seg[0]=a, active-low.
REQ-011 The block SHALL have port dp, output, 1 bit, decimal point cathode, active-low.
REQ-012 The block SHALL have port digit, output, NUM_DIGITS bits, anodes with bit i = digit i, active-low, one-hot-low or all-high.
REQ-013 The block SHALL have port pending, output, 1 bit, high while the shadow register holds data not yet displayed.
REQ-014 The block SHALL have port frame_done, output, 1 bit, one-cycle pulse at each frame boundary.

Function
REQ-015 Slot timer: the block SHALL count 0..REFRESH_CYCLES-1 and wrap; digit index SHALL increment on wrap and return to 0 after NUM_DIGITS-1.
REQ-016 Frame boundary is defined as timer==REFRESH_CYCLES-1 with index==NUM_DIGITS-1; frame_done SHALL be high in the cycle after it.
REQ-017 load=1 SHALL write value and dp_in into the shadow register and set pending=1 on the next edge.
REQ-018 At a frame boundary with pending=1, the block SHALL copy shadow to the active register and clear pending, so that no frame ever mixes old and new digits.
REQ-019 When load coincides with a frame boundary, the transfer SHALL use the pre-load shadow contents and pending SHALL remain 1, so the new data appears at the following boundary.
REQ-020 seg, dp and digit SHALL be registered and SHALL reflect the current index one clock after the index changes.
REQ-021 Glyphs SHALL be active-low in seg[0:6] order: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-022 With lz_blank=1, every digit above the most-significant non-zero active nibble SHALL show seg=1111111, and digit 0 SHALL never be blanked.
REQ-023 dp SHALL be the inverse of the active dp bit for the current digit, and SHALL NOT be blanked by lz_blank.
REQ-024 Changing lz_blank SHALL take effect immediately, because it is not shadowed.

Reset
REQ-025 While reset=0, the block SHALL hold seg=1111111, dp=1, digit=all ones, pending=0, frame_done=0, timer=0, index=0, and shadow and active registers all zero.
REQ-026 A reset asserted mid-frame or with pending=1 SHALL discard the shadow contents, and the first cycle after release SHALL start slot 0 of a new frame.

Configuration
REQ-027 With macro SEG7_MUX_PWM_EN defined, a free-running 4-bit PWM counter SHALL gate the anodes: digit SHALL be driven low only while pwm_cnt<=brightness, giving (brightness+1)/16 duty, and SHALL be all high otherwise.
REQ-028 With SEG7_MUX_PWM_EN undefined, the anodes SHALL be always enabled within each slot, the brightness port SHALL remain present but be ignored, and no PWM counter SHALL be synthesised.

Verification
REQ-029 Scenario: NUM_DIGITS=4, REFRESH_CYCLES=4, release reset -> digit steps 1110, 1101, 1011, 0111 every 4 clocks, frame_done pulses every 16 clocks, and all segments show 0000001.
REQ-030 Scenario: load value=16'h12AF mid-frame -> pending=1, the display stays 0 until the boundary, then shows F, A, 2, 1 on digits 0..3, and pending=0.
REQ-031 Scenario: lz_blank=1, value=16'h0005 -> digits 3..1 show seg=1111111 and digit 0 shows 0100100; with value=16'h0000, digit 0 shows 0000001.
REQ-032 Scenario: load pulsed exactly on the boundary cycle -> old shadow is displayed, pending stays 1, and the new value appears one frame later.
REQ-033 Scenario: SEG7_MUX_PWM_EN defined, brightness=3 -> anode low for 4 of every 16 clocks; brightness=15 -> always low within the slot.
REQ-034 Scenario: reset asserted with pending=1 mid-slot -> outputs go to reset values asynchronously, and after release the display shows 0 with pending=0.
